rev_universal_shift_reg: RTL

//  WIDTH-bit universal shift register built from the reversible D-flip-flop cell stage.

---
 rtl/rev_usr_pkg.sv | 14 +
 rtl/rev_universal_shift_reg_if.sv | 20 ++
 rtl/rev_usr_cell.sv | 19 +
 rtl/rev_universal_shift_reg.sv | 58 +++++
 4 files changed

// File: rtl/rev_usr_pkg.sv
// rev_usr_pkg: shared mode and FSM encodings for the reversible universal shift register
package rev_usr_pkg;
  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_SHR  = 2'b01,
    MODE_SHL  = 2'b10,
    MODE_LOAD = 2'b11
  } mode_t;
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;
endpackage

// File: rtl/rev_universal_shift_reg_if.sv
// rev_universal_shift_reg_if: command, serial and register-output bundle of the shift register
interface rev_universal_shift_reg_if #(parameter int WIDTH = 4, parameter int CNT_W = 3);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_mode;
  logic [CNT_W-1:0] cmd_count;
  logic [WIDTH-1:0] par_in;
  logic             ser_in_r;
  logic             ser_in_l;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qn;
  logic             ser_out_r;
  logic             ser_out_l;
  logic             busy;
  logic             done;
  modport master (output cmd_valid, cmd_mode, cmd_count, par_in, ser_in_r, ser_in_l,
                  input cmd_ready, q, qn, ser_out_r, ser_out_l, busy, done);
  modport slave  (input cmd_valid, cmd_mode, cmd_count, par_in, ser_in_r, ser_in_l,
                  output cmd_ready, q, qn, ser_out_r, ser_out_l, busy, done);
endinterface

// File: rtl/rev_usr_cell.sv
// rev_usr_cell: one register bit, 4:1 mode mux feeding a dual-rail D flop
import rev_usr_pkg::*;
module rev_usr_cell (
  input  logic  clk,
  input  logic  rst,
  input  mode_t mode,
  input  logic  from_left,
  input  logic  from_right,
  input  logic  load_d,
  output logic  q,
  output logic  qn
);
  logic d;
  always_comb d = mode == MODE_SHR ? from_left : mode == MODE_SHL ? from_right : mode == MODE_LOAD ? load_d : q;
  always_ff @(posedge clk) begin
    q  <= rst ? 1'b0 : d;
    qn <= rst ? 1'b1 : ~d;
  end
endmodule

// File: rtl/rev_universal_shift_reg.sv
// rev_universal_shift_reg: command-driven universal shift register with step FSM and down-counter
import rev_usr_pkg::*;
module rev_universal_shift_reg #(parameter int WIDTH = 4, parameter int CNT_W = 3) (
  input logic clk,
  input logic rst,
  rev_universal_shift_reg_if.slave bus
);
  state_t           state;
  mode_t            mode_r;
  mode_t            cell_mode;
  logic [CNT_W-1:0] remaining;
  logic [WIDTH-1:0] q_w, qn_w;
  logic             accept, is_shift;
  always_comb begin
    accept    = bus.cmd_valid && state == S_IDLE;
    is_shift  = bus.cmd_mode == MODE_SHR || bus.cmd_mode == MODE_SHL;
    cell_mode = accept && bus.cmd_mode == MODE_LOAD ? MODE_LOAD : state == S_RUN ? mode_r : MODE_HOLD;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      mode_r    <= MODE_HOLD;
      remaining <= '0;
    end else begin
      case (state)
        S_IDLE: if (accept) begin
          mode_r    <= mode_t'(bus.cmd_mode);
          remaining <= bus.cmd_count;
          state     <= is_shift && bus.cmd_count != '0 ? S_RUN : S_DONE;
        end
        S_RUN: begin
          remaining <= remaining - 1'b1;
          if (remaining == CNT_W'(1)) state <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    rev_usr_cell u_cell (
      .clk        (clk),
      .rst        (rst),
      .mode       (cell_mode),
      .from_left  (i == WIDTH-1 ? bus.ser_in_r : q_w[(i+1) % WIDTH]),
      .from_right (i == 0 ? bus.ser_in_l : q_w[(i+WIDTH-1) % WIDTH]),
      .load_d     (bus.par_in[i]),
      .q          (q_w[i]),
      .qn         (qn_w[i])
    );
  end
  assign bus.q         = q_w;
  assign bus.qn        = qn_w;
  assign bus.ser_out_r = q_w[0];
  assign bus.ser_out_l = q_w[WIDTH-1];
  assign bus.cmd_ready = state == S_IDLE;
  assign bus.busy      = state != S_IDLE;
  assign bus.done      = state == S_DONE;
endmodule
